serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor that replaces the single-bit subtract cell with a WIDTH-bit add/sub engine. Processes DIGIT bits per clock, LSB digit first.
- Subtraction is done by two's complement: A + ~B + 1.
- Supports four ops (ADD, SUB, ADC, SBB) and reports carry, signed overflow and zero flags.
- Sits between the operand registers and the result/flag registers of the datapath, using a start/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT, WIDTH >= 2
DIGIT, 1, bits processed per clock; N = WIDTH/DIGIT cycles per operation

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  request a new operation; sampled on rising edge
op  in  2  00 ADD, 01 SUB, 10 ADC (A+B+cin), 11 SBB (A-B-~cin, i.e. cin=1 means no borrow)
a  in  WIDTH  operand A, sampled with start
b  in  WIDTH  operand B, sampled with start
cin  in  1  carry-in for ADC/SBB, sampled with start; ignored for ADD/SUB
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when result and flags become valid
result  out  WIDTH  A op B, modulo 2^WIDTH
carry  out  1  final carry out; for SUB/SBB 1 = no borrow, 0 = borrow
ovf  out  1  two's-complement signed overflow
zero  out  1  result == 0

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state <= IDLE; busy, done, result, carry, ovf, zero all 0.
  - Internal operand shift registers and digit counter cleared.
  - Reset has priority over every other input, including mid-operation. A partial result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Latch a and b.
  - Latch b_eff: b for ADD/ADC, ~b for SUB/SBB.
  - Latch c0: 0 for ADD, 1 for SUB, cin for ADC/SBB.
  - counter <= 0; state <= RUN; busy <= 1; done <= 0.
- IDLE with start=0: hold. All outputs keep their last values.
- RUN, each edge:
  - Add digit k of A, digit k of b_eff and the running carry.
  - Write the DIGIT-bit sum into result digit k (shift-in from MSB side acceptable) and update the running carry.
  - counter increments.
- RUN on the edge processing digit N-1:
  - state <= DONE; busy <= 0; done <= 1.
  - carry <= carry out of bit WIDTH-1.
  - ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero <= (final result == 0).
- Latency: done is high in the cycle following the N-th edge after the edge that sampled start. Example: DIGIT=1, WIDTH=8 gives done visible after edge 8.
- DONE: lasts exactly one cycle.
  - Next edge with start=0: state <= IDLE, done <= 0.
  - Next edge with start=1: a new op is accepted per the IDLE rule (back-to-back).
- result and flags are stable from done until the edge that accepts the next start. They may change during RUN (partial result); consumers use them only on or after done.
- start while busy (RUN) is ignored. The in-flight operation is unaffected and no request is queued.
- a, b, op and cin are don't-care except on the edge that accepts start.
- DIGIT=WIDTH is legal: N=1, done one edge after start.

Decomposition:
- Package addsub_pkg:
  - Op encodings OP_ADD, OP_SUB, OP_ADC, OP_SBB.
  - State enum IDLE/RUN/DONE.
  - Width helper for the counter: clog2(WIDTH/DIGIT), minimum 1.
- Sub-module digit_adder (parameter DIGIT): combinational ripple adder.
  - Inputs: x, y, ci.
  - Outputs: s, co, and c_msb = carry into its top bit, used for ovf on the last digit.
- serial_addsub holds the FSM, counter, operand registers and flag registers.

Test Plan:
- WIDTH=8, DIGIT=2, ADD a=0x7F b=0x01 -> after 4 edges done=1 for one cycle; result=0x80, carry=0, ovf=1, zero=0; busy high for exactly 4 cycles.
- WIDTH=8, DIGIT=2, SUB a=0x00 b=0x01 -> result=0xFF, carry=0 (borrow), ovf=0, zero=0. Then SUB a=0x80 b=0x01 back-to-back (start high during DONE) -> result=0x7F, carry=1, ovf=1.
- WIDTH=8, DIGIT=1, ADC a=0xFF b=0x00 cin=1 -> done after 8 edges; result=0x00, carry=1, ovf=0, zero=1. Then SBB a=0x05 b=0x05 cin=0 -> result=0xFF, carry=0.
- Start pulse again 2 cycles into a RUN with different operands -> ignored; the first op's result is delivered at the original done time and no second done follows.
- rst_n=0 for one edge at cycle 2 of RUN -> next cycle busy=0, done=0, result=0, flags=0, state IDLE; no done ever produced for the aborted op.
- Randomised sweep, WIDTH=16 with DIGIT in {1,4,16}, all ops -> result/carry/ovf/zero match reference arithmetic; latency = WIDTH/DIGIT edges.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor:
// op encodings, FSM states and sizing helpers.
package addsub_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width; never below one bit.
  function automatic int cnt_width(
    input int width,
    input int digit
  );
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Initial carry into digit 0.
  function automatic logic carry0(
    input logic [1:0] op,
    input logic       cin
  );
    logic c;
    unique case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder.
// Ports: x, y, ci in; s sum, co carry out, c_msb carry into top bit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic cc;

  always_comb begin
    cc    = ci;
    s     = '0;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        c_msb = cc;
      end
      s[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    co = cc;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit add/sub engine, LSB digit first.
// Ports: clk, rst_n (sync, low), start/op/a/b/cin in;
//        busy, done, result, carry, ovf, zero out.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             zero_d;
  logic             busy_d;
  logic             done_d;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dmsb;
  logic [WIDTH-1:0] res_sh;
  logic             last;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .ci   (cy_q),
    .s    (dsum),
    .co   (dco),
    .c_msb(dmsb)
  );

  // New digit enters at the top; after N shifts
  // digit 0 has reached the bottom.
  assign res_sh = (result >> DIGIT)
                | (WIDTH'(dsum) << (WIDTH - DIGIT));

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    res_d   = result;
    carry_d = carry;
    ovf_d   = ovf;
    zero_d  = zero;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = op[0] ? ~b : b;
          cy_d    = carry0(op, cin);
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cy_d  = dco;
        cnt_d = cnt_q + CW'(1);
        res_d = res_sh;
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          carry_d = dco;
          ovf_d   = dco ^ dmsb;
          zero_d  = (res_sh == '0);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      result  <= res_d;
      carry   <= carry_d;
      ovf     <= ovf_d;
      zero    <= zero_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub across several
// WIDTH/DIGIT configurations.
module tb_serial_addsub;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
    int          t;
  } exp_t;

  localparam int NCFG = 5;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fin = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // op, a, b, cin, result, carry, ovf, zero
  vec_t v8 [11] = '{
    '{2'd0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0},
    '{2'd1, 16'h0000, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0},
    '{2'd1, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b1, 1'b1, 1'b0},
    '{2'd2, 16'h00FF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{2'd3, 16'h0005, 16'h0005, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0},
    '{2'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{2'd1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{2'd2, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1},
    '{2'd3, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0},
    '{2'd0, 16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0},
    '{2'd1, 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0}
  };

  vec_t v16 [11] = '{
    '{2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
    '{2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{2'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0},
    '{2'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0},
    '{2'd2, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0},
    '{2'd3, 16'h1000, 16'h0001, 1'b0, 16'h0FFE, 1'b1, 1'b0, 1'b0},
    '{2'd2, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1},
    '{2'd1, 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{2'd0, 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0},
    '{2'd3, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0},
    '{2'd0, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0}
  };

  task automatic chk(
    input string       nm,
    input int          cfg,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d: got %h expected %h (cycle %0d)",
               nm, cfg, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W = (g < 2) ? 8 : 16;
    localparam int D = (g == 0) ? 2 :
                       (g == 1) ? 1 :
                       (g == 2) ? 1 :
                       (g == 3) ? 4 : 16;
    localparam int N = W / D;

    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;

    exp_t q[$];
    exp_t em;

    serial_addsub #(
      .WIDTH(W),
      .DIGIT(D)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .result(result),
      .carry (carry),
      .ovf   (ovf),
      .zero  (zero)
    );

    function automatic vec_t pick(input int i);
      return (W == 8) ? v8[i] : v16[i];
    endfunction

    task automatic check_cleared(input string nm);
      chk({nm, "_busy"}, g, 32'(busy), 32'd0);
      chk({nm, "_done"}, g, 32'(done), 32'd0);
      chk({nm, "_result"}, g, 32'(result), 32'd0);
      chk({nm, "_carry"}, g, 32'(carry), 32'd0);
      chk({nm, "_ovf"}, g, 32'(ovf), 32'd0);
      chk({nm, "_zero"}, g, 32'(zero), 32'd0);
    endtask

    // Called at a falling edge; returns at the falling
    // edge of the expected done cycle.
    task automatic op_go(input vec_t v, input bit ign);
      exp_t e;
      start = 1'b1;
      op    = v.op;
      a     = v.a[W-1:0];
      b     = v.b[W-1:0];
      cin   = v.ci;
      e.r   = v.r;
      e.c   = v.c;
      e.v   = v.v;
      e.z   = v.z;
      e.t   = cyc + 1 + N;
      q.push_back(e);
      for (int k = 1; k <= N; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (ign && k == 2) begin
          start = 1'b1;
          a     = ~a;
          b     = ~b;
          op    = op ^ 2'b01;
          cin   = ~cin;
        end
        chk("busy_run", g, 32'(busy), 32'd1);
      end
      @(negedge clk);
      start = 1'b0;
      chk("busy_done", g, 32'(busy), 32'd0);
    endtask

    task automatic abort_op(input vec_t v);
      start = 1'b1;
      op    = v.op;
      a     = v.a[W-1:0];
      b     = v.b[W-1:0];
      cin   = v.ci;
      @(negedge clk);
      start = 1'b0;
      if (N >= 2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_cleared("abort");
      repeat (N + 3) @(negedge clk);
    endtask

    always @(negedge clk) begin
      if (rst_n && done) begin
        if (q.size() == 0) begin
          chk("spurious_done", g, 32'(done), 32'd0);
        end else begin
          em = q.pop_front();
          chk("result", g, 32'(result), 32'(em.r));
          chk("carry", g, 32'(carry), 32'(em.c));
          chk("ovf", g, 32'(ovf), 32'(em.v));
          chk("zero", g, 32'(zero), 32'(em.z));
          chk("latency", g, 32'(cyc), 32'(em.t));
        end
      end
    end

    initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 2'd0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1;
      @(negedge clk);
      // Odd-indexed vectors are issued back-to-back
      // with the done cycle of the previous one.
      for (int i = 0; i < 11; i++) begin
        if (i % 2 == 0) @(negedge clk);
        op_go(pick(i), 1'b0);
      end
      @(negedge clk);
      op_go(pick(0), N >= 3);
      @(negedge clk);
      abort_op(pick(1));
      @(negedge clk);
      op_go(pick(2), 1'b0);
      repeat (N + 4) @(negedge clk);
      chk("pending_done", g, 32'(q.size()), 32'd0);
      fin++;
    end
  end

  initial begin
    for (int k = 0; k < 20000 && fin < NCFG; k++) begin
      @(negedge clk);
    end
    chk("configs_finished", 0, 32'(fin), 32'(NCFG));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
